// File: rtl/irq_collector.sv
// Interrupt collector: synchronizes asynchronous interrupt lines, latches rising
// edges into APB-visible pending bits and presents a lowest-index-first request.
module irq_collector #(
  parameter int NUM_IRQ     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [11:0]        PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  input  logic [NUM_IRQ-1:0] apbsubsys_interrupt,
  input  logic               watchdog_interrupt,
  output logic               irq_out,
  output logic [4:0]         irq_id,
  output logic               nmi_out
);

  localparam logic [9:0] W_RAW    = 10'd0;
  localparam logic [9:0] W_PEND   = 10'd1;
  localparam logic [9:0] W_ENABLE = 10'd2;
  localparam logic [9:0] W_STATUS = 10'd3;
  localparam logic [9:0] W_ACTIVE = 10'd4;
  localparam logic [9:0] W_SWSET  = 10'd5;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0]              wdog_q, wdog_d;
  logic [NUM_IRQ-1:0]                  prev_q, prev_d;
  logic [NUM_IRQ-1:0]                  pending_q, pending_d;
  logic [NUM_IRQ-1:0]                  enable_q, enable_d;
  logic                                irq_out_q, irq_out_d;
  logic [4:0]                          irq_id_q, irq_id_d;

  logic [NUM_IRQ-1:0] raw, rise, status, wdata_n;
  logic [9:0]         word;
  logic               wr_en, mapped, ro_reg, wr_ok;
  logic [31:0]        rdata;
  logic               unused_ok;

  function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  assign unused_ok = ^{PADDR[1:0], PWDATA};

  always_comb begin
    raw     = sync_q[SYNC_STAGES-1];
    rise    = raw & ~prev_q;
    status  = pending_q & enable_q;
    word    = PADDR[11:2];
    wdata_n = PWDATA[NUM_IRQ-1:0];
    wr_en   = PSEL & PENABLE & PWRITE;
    mapped  = (word <= W_SWSET);
    ro_reg  = (word == W_RAW) || (word == W_STATUS) || (word == W_ACTIVE);
    wr_ok   = wr_en & mapped & ~ro_reg;
  end

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = apbsubsys_interrupt;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    wdog_d = {wdog_q[SYNC_STAGES-2:0], watchdog_interrupt};
    prev_d = raw;

    // Clear is applied first so a same-cycle hardware edge or SWSET wins.
    pending_d = pending_q;
    if (wr_ok && word == W_PEND) pending_d = pending_d & ~wdata_n;
    pending_d = pending_d | rise;
    if (wr_ok && word == W_SWSET) pending_d = pending_d | wdata_n;

    enable_d = enable_q;
    if (wr_ok && word == W_ENABLE) enable_d = wdata_n;

    irq_out_d = |status;
    irq_id_d  = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (status[i]) irq_id_d = 5'(i);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync_q    <= '0;
      wdog_q    <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      irq_out_q <= 1'b0;
      irq_id_q  <= 5'd0;
    end else begin
      sync_q    <= sync_d;
      wdog_q    <= wdog_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      irq_out_q <= irq_out_d;
      irq_id_q  <= irq_id_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      W_RAW:    rdata = zext(raw);
      W_PEND:   rdata = zext(pending_q);
      W_ENABLE: rdata = zext(enable_q);
      W_STATUS: rdata = zext(status);
      W_ACTIVE: rdata = {irq_out_q, 26'd0, irq_id_q};
      default:  rdata = '0;
    endcase
  end

  assign PRDATA  = PSEL ? rdata : 32'd0;
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & (~mapped | (PWRITE & ro_reg));
  assign irq_out = irq_out_q;
  assign irq_id  = irq_id_q;
  assign nmi_out = wdog_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_irq_collector.sv
// Directed bench for irq_collector: APB register access, edge latching,
// priority, error responses, NMI path and reset behaviour.
module tb_irq_collector;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] irq_in = '0;
  logic        wdog = 1'b0;
  logic        irq_out, nmi_out;
  logic [4:0]  irq_id;

  int n_checks = 0;
  int n_fail   = 0;

  irq_collector dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .apbsubsys_interrupt(irq_in),
    .watchdog_interrupt(wdog), .irq_out(irq_out), .irq_id(irq_id),
    .nmi_out(nmi_out)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  // Tasks start just after a rising edge; the write lands on the second edge.
  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    data = PRDATA;
    err  = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    n_checks++;
    if ({irq_out, irq_id, nmi_out} !== 7'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 0", {irq_out, irq_id, nmi_out});
    end
    n_checks++;
    if (PRDATA !== 32'd0 || PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      n_fail++; $display("FAIL reset_apb: got prdata=%h pready=%b pslverr=%b required 0/1/0", PRDATA, PREADY, PSLVERR);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    apb_read(12'h008, d, e);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_enable: got %h required 0", d); end
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h required 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic e;
    apb_write(12'h008, 32'h1, e);
    irq_in[0] = 1'b1;
    @(posedge PCLK); #1;
    irq_in[0] = 1'b0;
    @(posedge PCLK); @(posedge PCLK); @(negedge PCLK);
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL latency_early: irq_out got %b required 0 at k+2", irq_out); end
    @(posedge PCLK); @(negedge PCLK);
    n_checks++;
    if (irq_out !== 1'b1 || irq_id !== 5'd0) begin
      n_fail++; $display("FAIL latency_k3: got irq_out=%b id=%0d required 1/0", irq_out, irq_id);
    end
    @(posedge PCLK); #1;
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL basic_pending: got %h required 1", d); end
    apb_write(12'h004, 32'h1, e);
    @(negedge PCLK);
    n_checks++;
    if (irq_out !== 1'b1) begin n_fail++; $display("FAIL w1c_hold: irq_out got %b required 1", irq_out); end
    @(negedge PCLK);
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL w1c_clear: irq_out got %b required 0", irq_out); end
    @(posedge PCLK); #1;
  endtask

  task automatic test_priority();
    logic [31:0] d; logic e;
    apb_write(12'h008, 32'hFFFF_FFFF, e);
    irq_in[12] = 1'b1; irq_in[8] = 1'b1;
    tick(1);
    irq_in[12] = 1'b0; irq_in[8] = 1'b0;
    tick(5);
    n_checks++;
    if (irq_out !== 1'b1 || irq_id !== 5'd8) begin
      n_fail++; $display("FAIL prio_8: got out=%b id=%0d required 1/8", irq_out, irq_id);
    end
    apb_read(12'h010, d, e);
    n_checks++;
    if (d !== 32'h8000_0008) begin n_fail++; $display("FAIL prio_active: got %h required 80000008", d); end
    apb_write(12'h004, 32'h100, e);
    tick(2);
    n_checks++;
    if (irq_out !== 1'b1 || irq_id !== 5'd12) begin
      n_fail++; $display("FAIL prio_12: got out=%b id=%0d required 1/12", irq_out, irq_id);
    end
    apb_write(12'h004, 32'h1000, e);
    tick(2);
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL prio_none: irq_out got %b required 0", irq_out); end
    apb_read(12'h010, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL prio_active0: got %h required 0", d); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d; logic e;
    irq_in[4] = 1'b1;
    tick(1);
    apb_write(12'h004, 32'h10, e);  // lands on the same edge that latches the rise
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'h10) begin n_fail++; $display("FAIL set_wins: pending got %h required 10", d); end
    apb_write(12'h004, 32'h10, e);
    tick(6);
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL level_once: pending got %h required 0", d); end
    apb_read(12'h000, d, e);
    n_checks++;
    if (d !== 32'h10) begin n_fail++; $display("FAIL raw_level: got %h required 10", d); end
    irq_in[4] = 1'b0;
    tick(4);
  endtask

  task automatic test_enable_gate();
    logic [31:0] d; logic e;
    apb_write(12'h008, 32'h0, e);
    irq_in[9] = 1'b1;
    tick(1);
    irq_in[9] = 1'b0;
    tick(5);
    n_checks++;
    if (irq_out !== 1'b0) begin n_fail++; $display("FAIL masked_out: got %b required 0", irq_out); end
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'h200) begin n_fail++; $display("FAIL masked_pending: got %h required 200", d); end
    apb_write(12'h008, 32'h200, e);
    @(negedge PCLK);
    @(negedge PCLK);
    n_checks++;
    if (irq_out !== 1'b1 || irq_id !== 5'd9) begin
      n_fail++; $display("FAIL enable_9: got out=%b id=%0d required 1/9", irq_out, irq_id);
    end
    @(posedge PCLK); #1;
    apb_write(12'h008, 32'h0, e);
    tick(2);
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'h200 || irq_out !== 1'b0) begin
      n_fail++; $display("FAIL disable_keeps: got pending=%h out=%b required 200/0", d, irq_out);
    end
    apb_write(12'h008, 32'h200, e);
    tick(2);
    n_checks++;
    if (irq_out !== 1'b1) begin n_fail++; $display("FAIL reenable: got %b required 1", irq_out); end
    apb_write(12'h004, 32'h200, e);
    tick(2);
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e;
    apb_write(12'h014, 32'h30, e);
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'h30) begin n_fail++; $display("FAIL swset: pending got %h required 30", d); end
    apb_read(12'h014, d, e);
    n_checks++;
    if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL swset_read: got %h err=%b required 0/0", d, e); end
    apb_write(12'h004, 32'h0F0, e);
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_wide: pending got %h required 0", d); end
    apb_read(12'h020, d, e);
    n_checks++;
    if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("FAIL unmapped_read: got %h err=%b required 0/1", d, e); end
    apb_write(12'h008, 32'h5, e);
    apb_write(12'h00C, 32'hFFFF, e);
    n_checks++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL status_write_err: got %b required 1", e); end
    apb_write(12'h000, 32'hFFFF, e);
    n_checks++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL raw_write_err: got %b required 1", e); end
    apb_read(12'h008, d, e);
    n_checks++;
    if (d !== 32'h5 || e !== 1'b0) begin n_fail++; $display("FAIL ro_no_change: enable got %h err=%b required 5/0", d, e); end
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ro_no_pending: got %h required 0", d); end
  endtask

  task automatic test_nmi();
    logic [31:0] d; logic e;
    apb_write(12'h008, 32'h0, e);
    wdog = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    n_checks++;
    if (nmi_out !== 1'b0) begin n_fail++; $display("FAIL nmi_early: got %b required 0", nmi_out); end
    @(posedge PCLK); @(negedge PCLK);
    n_checks++;
    if (nmi_out !== 1'b1) begin n_fail++; $display("FAIL nmi_rise: got %b required 1", nmi_out); end
    @(posedge PCLK); #1;
    wdog = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    n_checks++;
    if (nmi_out !== 1'b1) begin n_fail++; $display("FAIL nmi_fall_early: got %b required 1", nmi_out); end
    @(posedge PCLK); @(negedge PCLK);
    n_checks++;
    if (nmi_out !== 1'b0) begin n_fail++; $display("FAIL nmi_fall: got %b required 0", nmi_out); end
    @(posedge PCLK); #1;
    apb_write(12'h008, 32'h1, e);
    irq_in[0] = 1'b1; wdog = 1'b1;
    tick(1);
    irq_in[0] = 1'b0;
    tick(5);
    n_checks++;
    if (irq_out !== 1'b1 || nmi_out !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got out=%b nmi=%b required 1/1", irq_out, nmi_out);
    end
    PRESET = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    n_checks++;
    if ({irq_out, irq_id, nmi_out} !== 7'd0) begin
      n_fail++; $display("FAIL reset_clears: got %b required 0", {irq_out, irq_id, nmi_out});
    end
    @(posedge PCLK); #1;
    wdog = 1'b0; PRESET = 1'b0;
    apb_read(12'h008, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_enable2: got %h required 0", d); end
  endtask

  task automatic test_reset_mid_apb();
    logic [31:0] d; logic e;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h008; PWDATA = 32'hFF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESET = 1'b0;
    apb_read(12'h008, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mid_apb: enable got %h required 0", d); end
  endtask

  task automatic test_held_reset();
    logic [31:0] d; logic e;
    irq_in[3] = 1'b1; PRESET = 1'b1;
    tick(3);
    PRESET = 1'b0;
    tick(8);
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL held_reset_set: pending got %h required 8", d); end
    apb_write(12'h004, 32'h8, e);
    tick(4);
    apb_read(12'h004, d, e);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL held_reset_once: pending got %h required 0", d); end
    irq_in[3] = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_set_wins();
    test_enable_gate();
    test_errors();
    test_nmi();
    test_reset_mid_apb();
    test_held_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
